overlay_text_ctrl: RTL and testbench
====================================

Name: overlay_text_ctrl

Overview:
- Sequences the font ROM for the text overlay path: tracks raster position from HDMI timing and fetches glyph bits for a row of characters at a programmable screen position.
- Holds a small character buffer written from switch/control logic.
- Drives the ROM address and read enable, plus a pixel-aligned overlay_enable and delayed sync signals.
- Sits between pixel_proc timing outputs and overlayBitRepiter/bit_combiner.

Parameters:
- NUM_CHARS, 8, characters in the text row (buffer depth, 1..16).
- CODE_W, 4, character code width (glyphs 0..2^CODE_W-1).
- GLYPH_W, 16, glyph width in pixels (power of 2).
- GLYPH_H, 32, glyph height in lines (power of 2).
- ROM_AW, 13, ROM address width; must equal CODE_W + log2(GLYPH_W*GLYPH_H).

Ports:
- HDMI_TX_CLK  in  1  pixel clock, the only clock.
- reset_n  in  1  asynchronous active-low reset.
- vpg_de  in  1  active video.
- vpg_hs  in  1  horizontal sync, active-low.
- vpg_vs  in  1  vertical sync, active-low.
- ovl_on  in  1  overlay master enable; sampled at frame start.
- x_pos  in  12  left pixel of text box; sampled at frame start.
- y_pos  in  12  top line of text box; sampled at frame start.
- char_we  in  1  character buffer write strobe.
- char_waddr  in  4  buffer slot (writes to slots >= NUM_CHARS are ignored).
- char_wdata  in  CODE_W  character code.
- rom_address  out  ROM_AW  font ROM bit address.
- rom_rden  out  1  ROM read enable.
- overlay_enable  out  1  current output pixel is inside a glyph cell; aligned with ROM q.
- pix_de, pix_hs, pix_vs  out  1 each  inputs delayed by 2 cycles.

Behaviour:
- Reset: all outputs 0, except pix_hs = pix_vs = 1. x/y counters 0, FSM in S_WAIT_VS, latched x_pos/y_pos/ovl_on 0, character buffer all 0.
- x counter: counts vpg_de-high cycles in a line, 0-based. Cleared on the cycle after vpg_de falls.
- y counter: counts active lines, incremented on each vpg_de falling edge. Cleared while vpg_vs = 0. Both counters are 12 bits and saturate at 4095; they do not wrap.
- Frame start is the vpg_vs falling edge. On that edge, latch x_pos, y_pos and ovl_on, then go to S_ABOVE. Changes to these inputs mid-frame have no effect until the next frame start.
- FSM states:
  - S_WAIT_VS: idle until frame start.
  - S_ABOVE: y < y_pos. Go to S_BAND when y == y_pos at the start of a line.
  - S_BAND: y_pos <= y < y_pos+GLYPH_H. Go to S_BELOW when y reaches y_pos+GLYPH_H.
  - S_BELOW: idle until the next frame start, then S_ABOVE.
  - Any frame start in any state goes to S_ABOVE. If latched ovl_on = 0, the FSM enters S_BELOW instead.
- Fetch window: inside S_BAND with vpg_de = 1 and x_pos <= x < x_pos + NUM_CHARS*GLYPH_W. Compute using 13-bit sums so the box end cannot overflow. A box extending past the line end is clipped by DE.
- Address, registered (cycle t+1 for input pixel at cycle t):
  - rom_address = {code[c], row, col}, where c = (x-x_pos)/GLYPH_W, col = (x-x_pos)%GLYPH_W, row = y-y_pos.
  - rom_rden = 1 only inside the fetch window. Outside it, rom_rden = 0 and rom_address holds its last value.
- Latency: the ROM returns q one cycle after the address (cycle t+2). overlay_enable = rom_rden delayed 1 cycle. pix_de/hs/vs equal the inputs delayed 2 cycles, so all outputs are mutually aligned.
- Character buffer write:
  - Takes effect the next cycle.
  - A write to the slot being fetched in the same cycle: the fetch uses the old code.
  - Writes are accepted at any time, including mid-frame, so mid-frame tearing on text is permitted.
- Reset mid-frame: outputs clear immediately, and no fetch occurs until a full vpg_vs falling edge has been seen.

Test Plan:
- 1920x1080 timing, x_pos=300, y_pos=500, ovl_on=1, buffer = 0..7. In line 500, overlay_enable goes high for exactly 128 cycles, starting 2 cycles after the DE pixel x=300. rom_address for pixel x=316 is {4'd1, 5'd0, 4'd0} = 512.
- Same setup: line 531 is fetched with row=31. Line 532 and lines 0..499 have rom_rden = 0 throughout. Exactly 32*128 = 4096 enables per frame.
- x_pos=1850 (box end 1978 > 1919): enables stop at the last DE pixel, giving 70 per line. No wrap onto the next line.
- y_pos changed from 500 to 100 mid-frame: the current frame still draws at line 500; the next frame draws at line 100. ovl_on cleared mid-frame: the next frame has zero enables.
- char_we to slot 2 with code 0xA during active band: glyph cell 2 uses code 10 from the following cycle. Write to slot 9 with NUM_CHARS=8: buffer unchanged.
- Assert reset_n=0 during S_BAND for 3 cycles: outputs go to reset values asynchronously. No enables until after the next vpg_vs falling edge.

Source files
------------

// File: rtl/overlay_text_ctrl_if.sv
// Signal bundle for overlay_text_ctrl: raster timing, text-box control and the
// character-buffer write port flow in; font ROM addressing and the pixel-aligned
// overlay/sync outputs flow out.
interface overlay_text_ctrl_if #(
    parameter int CODE_W = 4,
    parameter int ROM_AW = 13
);
    logic              vpg_de;
    logic              vpg_hs;
    logic              vpg_vs;
    logic              ovl_on;
    logic [11:0]       x_pos;
    logic [11:0]       y_pos;
    logic              char_we;
    logic [3:0]        char_waddr;
    logic [CODE_W-1:0] char_wdata;
    logic [ROM_AW-1:0] rom_address;
    logic              rom_rden;
    logic              overlay_enable;
    logic              pix_de;
    logic              pix_hs;
    logic              pix_vs;

    modport master (
        output vpg_de, vpg_hs, vpg_vs, ovl_on, x_pos, y_pos,
               char_we, char_waddr, char_wdata,
        input  rom_address, rom_rden, overlay_enable, pix_de, pix_hs, pix_vs
    );

    modport slave (
        input  vpg_de, vpg_hs, vpg_vs, ovl_on, x_pos, y_pos,
               char_we, char_waddr, char_wdata,
        output rom_address, rom_rden, overlay_enable, pix_de, pix_hs, pix_vs
    );
endinterface

// File: rtl/overlay_text_ctrl.sv
// Font ROM sequencer for the text overlay: tracks the raster from HDMI timing,
// fetches glyph bits for one row of characters at a frame-latched position and
// delays the syncs so overlay_enable, ROM q and pix_* all line up.
module overlay_text_ctrl #(
    parameter int NUM_CHARS = 8,
    parameter int CODE_W    = 4,
    parameter int GLYPH_W   = 16,
    parameter int GLYPH_H   = 32,
    parameter int ROM_AW    = 13
) (
    input  logic               HDMI_TX_CLK,
    input  logic               reset_n,
    overlay_text_ctrl_if.slave bus
);
    localparam int          COL_W     = $clog2(GLYPH_W);
    localparam int          ROW_W     = $clog2(GLYPH_H);
    localparam logic [12:0] BOX_W13   = 13'(NUM_CHARS * GLYPH_W);
    localparam logic [12:0] GLYPH_H13 = 13'(GLYPH_H);

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_ABOVE   = 2'd1,
        S_BAND    = 2'd2,
        S_BELOW   = 2'd3
    } state_t;

    // Raster counters stop at full scale instead of wrapping.
    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    state_t            state_q, state_d;
    logic [11:0]       x_q, x_d, y_q, y_d;
    logic [11:0]       xp_q, xp_d, yp_q, yp_d;
    logic              ovl_q, ovl_d;
    logic              vs_prev_q, vs_prev_d;
    logic              de_p1_q, de_p1_d, de_p2_q, de_p2_d;
    logic              hs_p1_q, hs_p1_d, hs_p2_q, hs_p2_d;
    logic              vs_p1_q, vs_p1_d, vs_p2_q, vs_p2_d;
    logic [CODE_W-1:0] char_buf_q [NUM_CHARS];
    logic [CODE_W-1:0] char_buf_d [NUM_CHARS];
    logic [ROM_AW-1:0] rom_address_q, rom_address_d;
    logic              rom_rden_q, rom_rden_d;
    logic              overlay_enable_q, overlay_enable_d;

    logic              de_fall, frame_start, fetch;
    logic [12:0]       band_end, box_lo, box_hi;
    logic [11:0]       rel_x, cidx;
    logic [CODE_W-1:0] code;

    // Edge detection, raster counters, frame-start latching and sync delay line.
    // vs_prev resets low so a reset taken while vsync is low never fakes a frame start.
    always_comb begin
        de_fall     = de_p1_q & ~bus.vpg_de;
        frame_start = vs_prev_q & ~bus.vpg_vs;
        vs_prev_d   = bus.vpg_vs;

        x_d = x_q;
        if (bus.vpg_de) begin
            x_d = sat_inc(x_q);
        end else if (de_fall) begin
            x_d = '0;
        end

        y_d = y_q;
        if (!bus.vpg_vs) begin
            y_d = '0;
        end else if (de_fall) begin
            y_d = sat_inc(y_q);
        end

        xp_d  = xp_q;
        yp_d  = yp_q;
        ovl_d = ovl_q;
        if (frame_start) begin
            xp_d  = bus.x_pos;
            yp_d  = bus.y_pos;
            ovl_d = bus.ovl_on;
        end

        de_p1_d = bus.vpg_de;
        de_p2_d = de_p1_q;
        hs_p1_d = bus.vpg_hs;
        hs_p2_d = hs_p1_q;
        vs_p1_d = bus.vpg_vs;
        vs_p2_d = vs_p1_q;
    end

    // Vertical band sequencing; a frame start from any state restarts the search.
    always_comb begin
        state_d  = state_q;
        band_end = {1'b0, yp_q} + GLYPH_H13;
        case (state_q)
            S_WAIT_VS: state_d = S_WAIT_VS;
            S_ABOVE: begin
                // ovl_on is latched on the frame-start cycle, so it is checked here.
                if (!ovl_q) begin
                    state_d = S_BELOW;
                end else if (!bus.vpg_de && (y_q == yp_q)) begin
                    state_d = S_BAND;
                end
            end
            S_BAND: begin
                if ({1'b0, y_q} >= band_end) begin
                    state_d = S_BELOW;
                end
            end
            S_BELOW:   state_d = S_BELOW;
            default:   state_d = S_WAIT_VS;
        endcase
        if (frame_start) begin
            state_d = S_ABOVE;
        end
    end

    // Fetch window and glyph address; the box end uses 13 bits so it cannot overflow.
    always_comb begin
        box_lo = {1'b0, xp_q};
        box_hi = box_lo + BOX_W13;
        rel_x  = x_q - xp_q;
        cidx   = rel_x >> COL_W;
        code   = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (cidx == 12'(i)) begin
                code = char_buf_q[i];
            end
        end
        fetch = (state_q == S_BAND) && bus.vpg_de &&
                ({1'b0, x_q} >= box_lo) && ({1'b0, x_q} < box_hi);

        rom_rden_d    = fetch;
        rom_address_d = rom_address_q;
        if (fetch) begin
            rom_address_d = {code, ROW_W'(y_q - yp_q), rel_x[COL_W-1:0]};
        end
        overlay_enable_d = rom_rden_q;
    end

    // Character buffer update; the fetch above reads the pre-write contents.
    always_comb begin
        char_buf_d = char_buf_q;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (bus.char_we && (bus.char_waddr == 4'(i))) begin
                char_buf_d[i] = bus.char_wdata;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT_VS;
        end else begin
            state_q <= state_d;
        end
    end

    // Raster tracking, frame-latched box position and input delay line.
    always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            xp_q      <= '0;
            yp_q      <= '0;
            ovl_q     <= 1'b0;
            vs_prev_q <= 1'b0;
            de_p1_q   <= 1'b0;
            de_p2_q   <= 1'b0;
            hs_p1_q   <= 1'b1;
            hs_p2_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            vs_p2_q   <= 1'b1;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            xp_q      <= xp_d;
            yp_q      <= yp_d;
            ovl_q     <= ovl_d;
            vs_prev_q <= vs_prev_d;
            de_p1_q   <= de_p1_d;
            de_p2_q   <= de_p2_d;
            hs_p1_q   <= hs_p1_d;
            hs_p2_q   <= hs_p2_d;
            vs_p1_q   <= vs_p1_d;
            vs_p2_q   <= vs_p2_d;
        end
    end

    // Character buffer storage.
    always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                char_buf_q[i] <= '0;
            end
        end else begin
            char_buf_q <= char_buf_d;
        end
    end

    // ROM request stage (t+1) and overlay enable stage aligned with ROM q (t+2).
    always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            rom_address_q    <= '0;
            rom_rden_q       <= 1'b0;
            overlay_enable_q <= 1'b0;
        end else begin
            rom_address_q    <= rom_address_d;
            rom_rden_q       <= rom_rden_d;
            overlay_enable_q <= overlay_enable_d;
        end
    end

    assign bus.rom_address    = rom_address_q;
    assign bus.rom_rden       = rom_rden_q;
    assign bus.overlay_enable = overlay_enable_q;
    assign bus.pix_de         = de_p2_q;
    assign bus.pix_hs         = hs_p2_q;
    assign bus.pix_vs         = vs_p2_q;
endmodule

// File: tb/tb_overlay_text_ctrl.sv
// Directed bench for overlay_text_ctrl on a reduced raster (160x40 active,
// 16-cycle line blanking, 2 vsync lines, 1 back porch, 1 front porch line).
module tb_overlay_text_ctrl;
    localparam int HACT = 160;
    localparam int HBL  = 16;
    localparam int VACT = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    overlay_text_ctrl_if #(.CODE_W(4), .ROM_AW(13)) bus ();

    overlay_text_ctrl #(
        .NUM_CHARS(8), .CODE_W(4), .GLYPH_W(16), .GLYPH_H(32), .ROM_AW(13)
    ) dut (
        .HDMI_TX_CLK(clk),
        .reset_n    (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int passes = 0;

    // Driver-side position of the pixel currently presented (-1 = blanking).
    int drv_line = -1;
    int drv_x    = -1;

    // Mid-frame event: 1 = char write, 2 = y_pos/ovl_on change, 3 = reset pulse.
    int ev_kind = 0, ev_line = 0, ev_x = 0, ev_slot = 0, ev_code = 0, ev_y = 0;
    logic ev_ovl = 1'b0;
    int rst_left = 0;
    int en_at_rst = 0;

    // Monitor state.
    int   en_total = 0, bad_en = 0, pipe_err = 0, skip = 3;
    int   out_line = 0, cur_cnt = 0, cur_first = -1, pix_x = 0;
    int   line_cnt [64];
    int   first_en_x [64];
    logic pde_prev = 1'b0, pvs_prev = 1'b1;
    logic h1_de = 1'b0, h2_de = 1'b0, h1_hs = 1'b1, h2_hs = 1'b1, h1_vs = 1'b1, h2_vs = 1'b1;
    int   prev_line = -1, prev_x = -1;
    int   cap_line [3];
    int   cap_x [3];
    logic [12:0] cap_addr [3];
    logic        cap_rden [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        pde_prev <= bus.pix_de;
        pvs_prev <= bus.pix_vs;
        if (bus.overlay_enable) en_total <= en_total + 1;
        if (bus.overlay_enable && !bus.pix_de) bad_en <= bad_en + 1;
        if (pvs_prev && !bus.pix_vs) begin
            out_line <= 0;
        end else if (pde_prev && !bus.pix_de) begin
            if (out_line < 64) begin
                line_cnt[out_line]   <= cur_cnt;
                first_en_x[out_line] <= cur_first;
            end
            out_line  <= out_line + 1;
            cur_cnt   <= 0;
            cur_first <= -1;
            pix_x     <= 0;
        end else if (bus.pix_de) begin
            pix_x <= pix_x + 1;
            if (bus.overlay_enable) begin
                cur_cnt <= cur_cnt + 1;
                if (cur_first < 0) cur_first <= pix_x;
            end
        end
        if (!rst_n) skip <= 3;
        else if (skip > 0) skip <= skip - 1;
        else if (bus.pix_de !== h2_de || bus.pix_hs !== h2_hs || bus.pix_vs !== h2_vs)
            pipe_err <= pipe_err + 1;
        h1_de <= bus.vpg_de; h2_de <= h1_de;
        h1_hs <= bus.vpg_hs; h2_hs <= h1_hs;
        h1_vs <= bus.vpg_vs; h2_vs <= h1_vs;
        for (int k = 0; k < 3; k++) begin
            if (prev_line == cap_line[k] && prev_x == cap_x[k]) begin
                cap_addr[k] <= bus.rom_address;
                cap_rden[k] <= bus.rom_rden;
            end
        end
        prev_line <= drv_line;
        prev_x    <= drv_x;
    end

    task automatic drive_cycle(input logic de, input logic hs, input logic vs,
                               input int ln, input int px);
        @(posedge clk); #1;
        bus.vpg_de  = de;
        bus.vpg_hs  = hs;
        bus.vpg_vs  = vs;
        drv_line    = ln;
        drv_x       = px;
        bus.char_we = 1'b0;
        if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst_n = 1'b1;
        end
        if (px >= 0 && ln == ev_line && px == ev_x) begin
            case (ev_kind)
                1: begin
                    bus.char_we    = 1'b1;
                    bus.char_waddr = 4'(ev_slot);
                    bus.char_wdata = 4'(ev_code);
                end
                2: begin
                    bus.y_pos  = 12'(ev_y);
                    bus.ovl_on = ev_ovl;
                end
                3: begin
                    rst_n    = 1'b0;
                    rst_left = 3;
                    #1;
                    chk("async_rst_rden", 32'(bus.rom_rden), 32'd0);
                    chk("async_rst_ovl_en", 32'(bus.overlay_enable), 32'd0);
                    chk("async_rst_addr", 32'(bus.rom_address), 32'd0);
                    chk("async_rst_pix_de", 32'(bus.pix_de), 32'd0);
                    chk("async_rst_pix_hs", 32'(bus.pix_hs), 32'd1);
                    chk("async_rst_pix_vs", 32'(bus.pix_vs), 32'd1);
                    en_at_rst = en_total;
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive_line(input logic active, input logic vs, input int ln);
        for (int p = 0; p < HACT; p++) drive_cycle(active, 1'b1, vs, ln, active ? p : -1);
        for (int p = 0; p < HBL; p++) drive_cycle(1'b0, !(p >= 4 && p < 8), vs, ln, -1);
    endtask

    task automatic run_frame();
        drive_line(1'b0, 1'b0, -1);
        drive_line(1'b0, 1'b0, -1);
        drive_line(1'b0, 1'b1, -1);
        for (int l = 0; l < VACT; l++) drive_line(1'b1, 1'b1, l);
        drive_line(1'b0, 1'b1, -1);
    endtask

    task automatic write_char(input int slot, input int code);
        @(posedge clk); #1;
        bus.char_we    = 1'b1;
        bus.char_waddr = 4'(slot);
        bus.char_wdata = 4'(code);
        @(posedge clk); #1;
        bus.char_we = 1'b0;
    endtask

    task automatic set_caps(input int l0, input int x0, input int l1, input int x1,
                            input int l2, input int x2);
        cap_line[0] = l0; cap_x[0] = x0;
        cap_line[1] = l1; cap_x[1] = x1;
        cap_line[2] = l2; cap_x[2] = x2;
    endtask

    int e0;

    initial begin
        bus.vpg_de = 1'b0; bus.vpg_hs = 1'b1; bus.vpg_vs = 1'b1;
        bus.ovl_on = 1'b1; bus.x_pos = 12'd20; bus.y_pos = 12'd4;
        bus.char_we = 1'b0; bus.char_waddr = 4'd0; bus.char_wdata = 4'd0;
        set_caps(-9, -9, -9, -9, -9, -9);
        #2 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_rden", 32'(bus.rom_rden), 32'd0);
        chk("rst_ovl_en", 32'(bus.overlay_enable), 32'd0);
        chk("rst_addr", 32'(bus.rom_address), 32'd0);
        chk("rst_pix_de", 32'(bus.pix_de), 32'd0);
        chk("rst_pix_hs", 32'(bus.pix_hs), 32'd1);
        chk("rst_pix_vs", 32'(bus.pix_vs), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) write_char(i, i);

        // Frame 1: box at (20,4), glyphs 0..7.
        set_caps(4, 36, 35, 147, 4, 148);
        e0 = en_total;
        run_frame();
        chk("f1_enables", 32'(en_total - e0), 32'd4096);
        chk("f1_line3", 32'(line_cnt[3]), 32'd0);
        chk("f1_line4", 32'(line_cnt[4]), 32'd128);
        chk("f1_line35", 32'(line_cnt[35]), 32'd128);
        chk("f1_line36", 32'(line_cnt[36]), 32'd0);
        chk("f1_first_x4", 32'(first_en_x[4]), 32'd20);
        chk("f1_addr_x36", 32'(cap_addr[0]), 32'd512);
        chk("f1_rden_x36", 32'(cap_rden[0]), 32'd1);
        chk("f1_addr_row31", 32'(cap_addr[1]), 32'd4095);
        chk("f1_rden_boxend", 32'(cap_rden[2]), 32'd0);

        // Frame 2: write slot 2 <= 10 on the cycle pixel (5,52) is presented.
        set_caps(5, 52, 5, 53, 6, 52);
        ev_kind = 1; ev_line = 5; ev_x = 52; ev_slot = 2; ev_code = 10;
        run_frame();
        ev_kind = 0;
        chk("f2_same_cycle_old", 32'(cap_addr[0]), 32'd1040);
        chk("f2_next_cycle_new", 32'(cap_addr[1]), 32'd5137);
        chk("f2_next_line_new", 32'(cap_addr[2]), 32'd5152);

        // Slot 9 is out of range and must not alias onto slot 1.
        write_char(9, 15);

        // Frame 3: y_pos moved to 6 mid-frame; this frame still draws at line 4.
        set_caps(4, 36, 4, 52, 3, 36);
        ev_kind = 2; ev_line = 2; ev_x = 0; ev_y = 6; ev_ovl = 1'b1;
        e0 = en_total;
        run_frame();
        ev_kind = 0;
        chk("f3_enables", 32'(en_total - e0), 32'd4096);
        chk("f3_line4", 32'(line_cnt[4]), 32'd128);
        chk("f3_line36", 32'(line_cnt[36]), 32'd0);
        chk("f3_slot9_ignored", 32'(cap_addr[0]), 32'd512);
        chk("f3_slot2_kept", 32'(cap_addr[1]), 32'd5120);
        chk("f3_rden_above", 32'(cap_rden[2]), 32'd0);

        // Frame 4: band at line 6; ovl_on cleared mid-frame.
        set_caps(6, 20, 37, 20, 37, 36);
        ev_kind = 2; ev_line = 2; ev_x = 0; ev_y = 6; ev_ovl = 1'b0;
        e0 = en_total;
        run_frame();
        ev_kind = 0;
        chk("f4_enables", 32'(en_total - e0), 32'd4096);
        chk("f4_line5", 32'(line_cnt[5]), 32'd0);
        chk("f4_line6", 32'(line_cnt[6]), 32'd128);
        chk("f4_line37", 32'(line_cnt[37]), 32'd128);
        chk("f4_addr_top", 32'(cap_addr[0]), 32'd0);
        chk("f4_rden_top", 32'(cap_rden[0]), 32'd1);
        chk("f4_addr_bot0", 32'(cap_addr[1]), 32'd496);
        chk("f4_addr_bot1", 32'(cap_addr[2]), 32'd1008);

        // Frame 5: overlay off.
        e0 = en_total;
        run_frame();
        chk("f5_enables_off", 32'(en_total - e0), 32'd0);

        // Frame 6: box clipped by DE at x_pos=100.
        bus.ovl_on = 1'b1; bus.x_pos = 12'd100; bus.y_pos = 12'd4;
        set_caps(4, 159, 5, 100, 4, 99);
        e0 = en_total;
        run_frame();
        chk("f6_enables_clip", 32'(en_total - e0), 32'd1920);
        chk("f6_line4", 32'(line_cnt[4]), 32'd60);
        chk("f6_line5", 32'(line_cnt[5]), 32'd60);
        chk("f6_first_x4", 32'(first_en_x[4]), 32'd100);
        chk("f6_first_x5", 32'(first_en_x[5]), 32'd100);
        chk("f6_addr_last", 32'(cap_addr[0]), 32'd1547);
        chk("f6_rden_last", 32'(cap_rden[0]), 32'd1);
        chk("f6_addr_row1", 32'(cap_addr[1]), 32'd16);
        chk("f6_rden_before", 32'(cap_rden[2]), 32'd0);

        // Frame 7: reset pulse inside the band.
        bus.x_pos = 12'd20;
        e0 = en_total;
        ev_kind = 3; ev_line = 10; ev_x = 60;
        run_frame();
        ev_kind = 0;
        chk("f7_drew_before_rst", 32'((en_at_rst - e0) >= 768), 32'd1);
        chk("f7_no_en_after_rst", 32'(en_total - en_at_rst), 32'd0);

        // Frame 8: drawing resumes with a cleared buffer.
        set_caps(4, 36, 4, 35, -9, -9);
        e0 = en_total;
        run_frame();
        chk("f8_enables", 32'(en_total - e0), 32'd4096);
        chk("f8_addr_cleared", 32'(cap_addr[0]), 32'd0);
        chk("f8_rden", 32'(cap_rden[0]), 32'd1);
        chk("f8_addr_prev", 32'(cap_addr[1]), 32'd15);

        chk("en_outside_de", 32'(bad_en), 32'd0);
        chk("sync_delay_2", 32'(pipe_err), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
